port_bundle_driver: RTL
=======================

Name: port_bundle_driver

Overview:
- Source-side counterpart to the port-shape sink module.
- Accepts a byte stream over a valid/ready handshake and assembles each 4-byte frame into the full port bundle: packed vector, unpacked vector, packed 2-D, unpacked 2-D, packed struct, and unpacked array of packed struct.
- Presents the bundle with valid and waits for ack, with an optional timeout. Used on the bench and in-design to drive any consumer with that port set.

Parameters:
- ACK_TIMEOUT, 15: cycles in PRESENT without ack before the frame is dropped. 0 disables the timeout.
- CNT_W, 8: width of the delivered-frame counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  byte beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  8  beat payload; first beat is frame byte 0.
- out_valid  output  1  bundle valid.
- out_ack  input  1  consumer accepts the bundle.
- pack  output  [2:0]  packed vector.
- unpack  output  1 x [2:0] unpacked  unpacked vector.
- pack_md  output  [2:0][2:0]  packed 2-D.
- unpack_md  output  1 x [2:0][2:0] unpacked  unpacked 2-D.
- pack_str  output  pack_str_t (2 bits: a, b)  packed struct.
- pack_pack_str  output  pack_str_t x [2:0] unpacked  unpacked array of struct.
- timeout  output  1  one-cycle pulse when a frame is dropped.
- frame_cnt  output  CNT_W  frames acked; wraps at 2^CNT_W.

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - state = COLLECT, beat_cnt = 0.
  - in_ready = 1, out_valid = 0, timeout = 0, frame_cnt = 0.
  - All bundle outputs = 0, partial frame buffer = 0.
- Reset mid-frame or mid-PRESENT discards the frame. No ack or timeout is produced for it.
- Frame word F[31:0] = {byte3, byte2, byte1, byte0}. Field mapping:
  - pack = F[2:0].
  - unpack[i] = F[3+i].
  - pack_md[i][j] = F[6+3i+j].
  - unpack_md[i][j] = F[15+3i+j].
  - pack_str.a = F[25], pack_str.b = F[24].
  - pack_pack_str[i] = F[27+2i : 26+2i], with .a as the upper bit.
- COLLECT state:
  - in_ready = 1. A beat transfers when in_valid && in_ready; the byte is stored at slot beat_cnt and beat_cnt increments.
  - Transfer of beat 3 moves the state to PRESENT. All bundle outputs update from the full frame and out_valid rises on the same edge, so latency from the last beat to out_valid is 1 cycle.
  - in_valid low inserts idle cycles with no state change.
- PRESENT state:
  - in_ready = 0. Bundle outputs are held stable.
  - out_ack high moves the state to COLLECT. On the next edge: out_valid = 0, frame_cnt + 1, beat_cnt = 0. A new beat is accepted no earlier than the cycle after the ack.
  - Wait counter: cleared on entry to PRESENT, increments each PRESENT cycle without ack.
  - When ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT-1 without ack:
    - Next edge: timeout = 1 for one cycle, out_valid = 0, state = COLLECT.
    - frame_cnt is unchanged.
- Simultaneous ack and timeout on the same cycle: ack wins, the frame is counted, and no timeout pulse occurs.
- Bundle outputs keep their last value after ack or timeout until the next frame completes. Consumers must qualify them with out_valid.
- out_ack while in COLLECT is ignored.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset during beat 2 of a frame, then release and send 4 new beats -> the first bundle reflects only the new beats; out_valid = 0 throughout reset; frame_cnt = 0 until ack.
- Send bytes A5, 3C, 0F, F0 back-to-back with out_ack = 0 -> out_valid rises 1 cycle after the 4th beat, with:
  - pack = 3'b101, unpack = {1, 0, 0} for [2..0].
  - pack_str = 2'b00.
  - pack_pack_str[0] = 00, [1] = 11, [2] = 11.
  - in_ready = 0 while out_valid = 1.
- Same frame, assert out_ack on the 3rd PRESENT cycle -> out_valid drops next edge, frame_cnt = 1, in_ready = 1, no timeout pulse.
- Hold out_ack = 0 with ACK_TIMEOUT = 15 -> timeout pulses 1 cycle exactly 15 cycles after out_valid rose; frame_cnt stays 0; the next frame is accepted.
- Assert out_ack on the same cycle as the timeout threshold -> frame_cnt increments and timeout stays 0.
- Gapped in_valid (1, 0, 0, 1, 1, 0, 1) -> exactly 4 beats are accepted with the correct byte order; send 256 frames with CNT_W = 8 -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/port_bundle_driver.sv
// Byte-stream to port-bundle source: collects 4-byte frames, presents them
// as a multi-shape port bundle with valid/ack, and drops unacked frames
// after an optional timeout.

package port_bundle_driver_pkg;
  typedef struct packed {
    logic a;
    logic b;
  } pack_str_t;
endpackage

module port_bundle_driver
  import port_bundle_driver_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [2:0]       pack,
  output logic             unpack [2:0],
  output logic [2:0][2:0]  pack_md,
  output logic             unpack_md [2:0][2:0],
  output pack_str_t        pack_str,
  output pack_str_t        pack_pack_str [2:0],
  output logic             timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned WaitW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam bit TimeoutEn = (ACK_TIMEOUT != 0);

  typedef enum logic {StCollect, StPresent} state_e;

  state_e           state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  logic [23:0]      buf_q, buf_d;      // bytes 0..2 of the frame in progress
  logic [31:0]      bundle_q, bundle_d; // last completed frame word
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StCollect;
      beat_q    <= '0;
      buf_q     <= '0;
      bundle_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      buf_q     <= buf_d;
      bundle_q  <= bundle_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: beat collection, presentation, ack and timeout handling
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    bundle_d  = bundle_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      StCollect: begin
        if (in_valid) begin
          unique case (beat_q)
            2'd0: buf_d[7:0]   = in_data;
            2'd1: buf_d[15:8]  = in_data;
            2'd2: buf_d[23:16] = in_data;
            2'd3: begin
              bundle_d = {in_data, buf_q};
              state_d  = StPresent;
              wait_d   = '0;
            end
            default: ;
          endcase
          beat_d = beat_q + 2'd1;
        end
      end
      StPresent: begin
        // Ack takes priority over a timeout on the same cycle
        if (out_ack) begin
          state_d = StCollect;
          cnt_d   = cnt_q + 1'b1;
          beat_d  = '0;
        end else if (TimeoutEn && (wait_q == WaitMax)) begin
          state_d   = StCollect;
          timeout_d = 1'b1;
          beat_d    = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // Outputs: handshake flags and field slicing of the held frame word
  always_comb begin
    in_ready  = (state_q == StCollect);
    out_valid = (state_q == StPresent);
    timeout   = timeout_q;
    frame_cnt = cnt_q;
    pack      = bundle_q[2:0];
    pack_md   = bundle_q[14:6];
    pack_str  = bundle_q[25:24];
    for (int i = 0; i < 3; i++) begin
      unpack[i]        = bundle_q[3+i];
      pack_pack_str[i] = bundle_q[26+2*i +: 2];
      for (int j = 0; j < 3; j++) begin
        unpack_md[i][j] = bundle_q[15+3*i+j];
      end
    end
  end

endmodule
